// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: opcodes, FSM states,
// instruction field positions and the decoded control bundle.
package cpu_pkg;

    localparam int IW = 20;
    localparam int PW = 8;

    localparam int OP_MSB  = 19;
    localparam int OP_LSB  = 16;
    localparam int FN_MSB  = 15;
    localparam int FN_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RA_MSB  = 7;
    localparam int RA_LSB  = 4;
    localparam int RB_MSB  = 3;
    localparam int RB_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_CMP  = 4'h2;
    localparam logic [3:0] OP_LDI  = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_BZ   = 4'h5;
    localparam logic [3:0] OP_BC   = 4'h6;
    localparam logic [3:0] OP_HALT = 4'h7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_HALT
    } state_t;

    typedef struct packed {
        logic       alu_en;
        logic [3:0] alu_opcode;
        logic [7:0] user_write_data;
        logic [3:0] write_addr;
        logic [3:0] ra_addr;
        logic [3:0] rb_addr;
        logic       write_en;
    } ctrl_t;

    function automatic logic [3:0] ir_op(input logic [IW-1:0] ir);
        return ir[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/control_sequencer_decode.sv
// Purely combinational instruction decode: IR in, datapath controls
// and instruction class flags out.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [IW-1:0] ir,
    output ctrl_t         ctrl,
    output logic          is_branch,
    output logic          is_halt,
    output logic          is_illegal,
    output logic          sets_flags
);

    always_comb begin
        ctrl       = '0;
        is_branch  = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        sets_flags = 1'b0;
        unique case (ir_op(ir))
            OP_NOP: ;
            OP_ALU, OP_CMP: begin
                ctrl.alu_en     = 1'b1;
                ctrl.alu_opcode = ir[FN_MSB:FN_LSB];
                ctrl.ra_addr    = ir[RA_MSB:RA_LSB];
                ctrl.rb_addr    = ir[RB_MSB:RB_LSB];
                ctrl.write_addr = ir[RD_MSB:RD_LSB];
                ctrl.write_en   = (ir_op(ir) == OP_ALU);
                sets_flags      = 1'b1;
            end
            OP_LDI: begin
                ctrl.user_write_data = ir[IMM_MSB:IMM_LSB];
                ctrl.write_addr      = ir[RD_MSB:RD_LSB];
                ctrl.write_en        = 1'b1;
            end
            OP_JMP, OP_BZ, OP_BC: is_branch = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXECUTE FSM, pc and
// zero/carry flags; datapath controls are asserted only in EXECUTE.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [PW-1:0] instr_addr,
    input  logic [IW-1:0] instr_data,
    output logic          alu_en,
    output logic [3:0]    alu_opcode,
    output logic [7:0]    user_write_data,
    output logic [3:0]    write_addr,
    output logic [3:0]    ra_addr,
    output logic [3:0]    rb_addr,
    output logic          write_en,
    input  logic          alu_zero,
    input  logic          alu_carry,
    output logic [PW-1:0] pc,
    output logic          running,
    output logic          halted,
    output logic          illegal_op
);

    state_t        state;
    logic [IW-1:0] ir;
    logic          zf;
    logic          cf;
    ctrl_t         dec;
    ctrl_t         ctrl;
    logic          is_branch;
    logic          is_halt;
    logic          is_illegal;
    logic          sets_flags;
    logic          taken;

    instr_decode u_dec (
        .ir         (ir),
        .ctrl       (dec),
        .is_branch  (is_branch),
        .is_halt    (is_halt),
        .is_illegal (is_illegal),
        .sets_flags (sets_flags)
    );

    // Gating on the state register lets reset kill write_en at once.
    assign ctrl = (state == S_EXECUTE) ? dec : '0;

    assign alu_en          = ctrl.alu_en;
    assign alu_opcode      = ctrl.alu_opcode;
    assign user_write_data = ctrl.user_write_data;
    assign write_addr      = ctrl.write_addr;
    assign ra_addr         = ctrl.ra_addr;
    assign rb_addr         = ctrl.rb_addr;
    assign write_en        = ctrl.write_en;
    assign instr_addr      = pc;

    always_comb begin
        taken = 1'b0;
        unique case (ir_op(ir))
            OP_JMP:  taken = is_branch;
            OP_BZ:   taken = is_branch & zf;
            OP_BC:   taken = is_branch & cf;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            ir         <= '0;
            zf         <= 1'b0;
            cf         <= 1'b0;
            running    <= 1'b0;
            halted     <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state      <= S_FETCH;
                        pc         <= '0;
                        illegal_op <= 1'b0;
                        running    <= 1'b1;
                        halted     <= 1'b0;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ir    <= instr_data;
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (sets_flags) begin
                        zf <= alu_zero;
                        cf <= alu_carry;
                    end
                    if (is_halt || is_illegal) begin
                        state      <= S_HALT;
                        running    <= 1'b0;
                        halted     <= 1'b1;
                        illegal_op <= is_illegal;
                    end else begin
                        state <= S_FETCH;
                        pc    <= taken ? ir[IMM_MSB:IMM_LSB] : pc + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a registered-read program ROM.
module tb_control_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  instr_addr;
    logic [19:0] instr_data;
    logic        alu_en;
    logic [3:0]  alu_opcode;
    logic [7:0]  user_write_data;
    logic [3:0]  write_addr;
    logic [3:0]  ra_addr;
    logic [3:0]  rb_addr;
    logic        write_en;
    logic        alu_zero;
    logic        alu_carry;
    logic [7:0]  pc;
    logic        running;
    logic        halted;
    logic        illegal_op;

    logic [19:0] rom [256];
    int          nvec;
    int          nerr;
    int          we_count;
    int          we_base;
    int          we_cyc [$];

    control_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .instr_addr      (instr_addr),
        .instr_data      (instr_data),
        .alu_en          (alu_en),
        .alu_opcode      (alu_opcode),
        .user_write_data (user_write_data),
        .write_addr      (write_addr),
        .ra_addr         (ra_addr),
        .rb_addr         (rb_addr),
        .write_en        (write_en),
        .alu_zero        (alu_zero),
        .alu_carry       (alu_carry),
        .pc              (pc),
        .running         (running),
        .halted          (halted),
        .illegal_op      (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) instr_data <= rom[instr_addr];

    always @(negedge clk) if (write_en) we_count++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge of cycle 1 (FETCH).
    task automatic go();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) rom[i] = 20'h70000;
    endtask

    initial begin
        nvec      = 0;
        nerr      = 0;
        we_count  = 0;
        alu_zero  = 1'b0;
        alu_carry = 1'b0;
        fill_halt();
        do_reset();

        check("rst_pc", pc, 0);
        check("rst_running", running, 0);
        check("rst_halted", halted, 0);
        check("rst_we", write_en, 0);
        check("rst_illegal", illegal_op, 0);
        adv(3);
        check("idle_hold", running, 0);

        // LDI r1,5; LDI r2,3; ALU add r3,r1,r2; HALT
        rom[0] = 20'h30105;
        rom[1] = 20'h30203;
        rom[2] = 20'h10312;
        rom[3] = 20'h70000;
        go();
        for (int n = 1; n <= 12; n++) begin
            if (write_en) we_cyc.push_back(n);
            if (n == 3) begin
                check("ldi_data", user_write_data, 8'h05);
                check("ldi_waddr", write_addr, 1);
                check("ldi_alu_en", alu_en, 0);
            end
            if (n == 9) begin
                check("alu_en", alu_en, 1);
                check("alu_waddr", write_addr, 3);
                check("alu_ra", ra_addr, 1);
                check("alu_rb", rb_addr, 2);
            end
            adv(1);
        end
        check("we_pulses", we_cyc.size(), 3);
        if (we_cyc.size() == 3) begin
            check("we_cyc0", we_cyc[0], 3);
            check("we_cyc1", we_cyc[1], 6);
            check("we_cyc2", we_cyc[2], 9);
        end
        check("halt_halted", halted, 1);
        check("halt_pc", pc, 3);
        check("halt_illegal", illegal_op, 0);

        // CMP then BZ 0x40, zero set
        fill_halt();
        rom[0] = 20'h20012;
        rom[1] = 20'h50040;
        alu_zero = 1'b1;
        we_base = we_count;
        go();
        adv(2);
        check("cmp_alu_en", alu_en, 1);
        check("cmp_we", write_en, 0);
        adv(4);
        check("bz_taken_pc", pc, 8'h40);
        check("bz_no_write", we_count - we_base, 0);
        adv(3);
        check("bz_halted", halted, 1);

        // Same with zero clear: falls through
        alu_zero = 1'b0;
        go();
        adv(6);
        check("bz_fall_pc", pc, 8'h02);
        adv(3);

        // CMP then BC 0x40, carry set
        rom[1] = 20'h60040;
        alu_carry = 1'b1;
        go();
        adv(6);
        check("bc_taken_pc", pc, 8'h40);
        adv(3);
        alu_carry = 1'b0;

        // JMP 0xFF, NOP at 0xFF wraps
        fill_halt();
        rom[0]    = 20'h400FF;
        rom[8'hFF] = 20'h00000;
        go();
        adv(3);
        check("jmp_pc", pc, 8'hFF);
        adv(3);
        check("wrap_pc", pc, 8'h00);
        check("wrap_running", running, 1);
        do_reset();

        // Illegal opcode 0xA at pc 2
        fill_halt();
        rom[0] = 20'h00000;
        rom[1] = 20'h00000;
        rom[2] = 20'hA0000;
        we_base = we_count;
        go();
        adv(9);
        check("ill_halted", halted, 1);
        check("ill_flag", illegal_op, 1);
        check("ill_pc", pc, 8'h02);
        check("ill_no_write", we_count - we_base, 0);
        go();
        check("restart_pc", pc, 0);
        check("restart_ill", illegal_op, 0);
        check("restart_run", running, 1);
        do_reset();

        // Reset mid-EXECUTE of LDI at pc 1
        fill_halt();
        rom[0] = 20'h00000;
        rom[1] = 20'h30105;
        go();
        adv(5);
        check("pre_rst_we", write_en, 1);
        check("pre_rst_pc", pc, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_we_drop", write_en, 0);
        check("rst_pc_clr", pc, 0);
        check("rst_run_clr", running, 0);
        @(negedge clk);
        rst_n = 1'b1;
        adv(4);
        check("post_rst_idle", running, 0);
        check("post_rst_halt", halted, 0);

        // start held through FETCH/DECODE/EXECUTE is ignored
        fill_halt();
        rom[0] = 20'h00000;
        rom[1] = 20'h00000;
        rom[2] = 20'h00000;
        start = 1'b1;
        @(negedge clk);
        adv(3);
        check("ign_pc1", pc, 1);
        adv(2);
        start = 1'b0;
        adv(1);
        check("ign_pc2", pc, 2);
        check("ign_running", running, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
